// File: rtl/pwm_dac_ns.sv
`timescale 1ns/1ps
// pwm_dac_ns: 1-bit PWM audio DAC with a one-entry sample buffer, offset-binary
// conversion, optional first-order noise shaping and edge/center-aligned carrier.
module pwm_dac_ns #(
    parameter int unsigned IN_W        = 12,
    parameter int unsigned CNT_W       = 10,
    parameter int unsigned CENTER      = 0,
    parameter int unsigned NOISE_SHAPE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [IN_W-1:0] din,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic                   pwm_out,
    output logic                   period_start,
    output logic                   underrun
);

    localparam logic [CNT_W-1:0] MAX_CNT  = '1;
    localparam logic [CNT_W-1:0] MID_DUTY = {1'b1, {(CNT_W-1){1'b0}}};

    logic [CNT_W-1:0] cnt;
    logic             dirUp;
    logic             bufFull;
    logic [IN_W-1:0]  bufData;
    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] dutyEff;
    logic [CNT_W-1:0] convDuty;
    logic [IN_W-1:0]  uSample;
    logic             boundary;
    logic             loadSample;
    logic             accept;

    // Ready is purely the buffer state, so it never depends on din_valid.
    assign din_ready  = !bufFull;
    assign accept     = din_valid && !bufFull;
    assign boundary   = (cnt == '0) && dirUp;
    assign loadSample = boundary && bufFull;
    assign uSample    = {~bufData[IN_W-1], bufData[IN_W-2:0]};
    assign dutyEff    = loadSample ? convDuty : duty;

    // Sample-to-duty conversion, selected by the width relationship.
    if (IN_W <= CNT_W) begin : gPad
        assign convDuty = CNT_W'(uSample) << (CNT_W - IN_W);
    end else if (NOISE_SHAPE == 0) begin : gTrunc
        assign convDuty = CNT_W'(uSample >> (IN_W - CNT_W));
    end else begin : gShape
        localparam int unsigned ERR_W = IN_W - CNT_W;
        localparam int unsigned SUM_W = IN_W + 1;

        logic [ERR_W-1:0] err;
        logic [SUM_W-1:0] sum;

        assign sum      = SUM_W'(uSample) + SUM_W'(err);
        assign convDuty = sum[IN_W] ? MAX_CNT : sum[IN_W-1 -: CNT_W];

        // Truncation residue carried to the next consumed sample; cleared on saturation.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                err <= '0;
            end else if (loadSample) begin
                err <= sum[IN_W] ? '0 : sum[ERR_W-1:0];
            end
        end
    end

    // Carrier counter: sawtooth, or triangle holding each turning point for two cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            dirUp <= 1'b1;
        end else if (CENTER == 0) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dirUp) begin
            if (cnt == MAX_CNT) dirUp <= 1'b0;
            else                cnt   <= cnt + CNT_W'(1);
        end else begin
            if (cnt == '0) dirUp <= 1'b1;
            else           cnt   <= cnt - CNT_W'(1);
        end
    end

    // One-entry sample buffer: filled by the handshake, drained at a period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bufFull <= 1'b0;
            bufData <= '0;
        end else if (loadSample) begin
            bufFull <= 1'b0;
        end else if (accept) begin
            bufFull <= 1'b1;
            bufData <= din;
        end
    end

    // Duty holds across periods so an empty buffer repeats the last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty <= MID_DUTY;
        end else if (loadSample) begin
            duty <= convDuty;
        end
    end

    // Registered outputs, one clock behind the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            pwm_out      <= (cnt < dutyEff);
            period_start <= boundary;
            underrun     <= boundary && !bufFull;
        end
    end

endmodule

// File: tb/tb_pwm_dac_ns.sv
`timescale 1ns/1ps
// tb_pwm_dac_ns: scoreboard bench for an edge-aligned noise-shaped instance (0)
// and a center-aligned truncating instance (1).
module tb_pwm_dac_ns;

    localparam int unsigned IN_W = 12;

    typedef struct {
        int high;
        bit ur;
    } expEntry_t;

    logic                   clk;
    logic                   rstV   [2];
    logic signed [IN_W-1:0] dinV   [2];
    logic                   validV [2];
    logic                   readyV [2];
    logic                   pwmV   [2];
    logic                   psV    [2];
    logic                   urV    [2];

    expEntry_t expQ [2][$];

    int checks;
    int errors;

    pwm_dac_ns #(.IN_W(12), .CNT_W(10), .CENTER(0), .NOISE_SHAPE(1)) dutEdge (
        .clk(clk), .rst_n(rstV[0]), .din(dinV[0]), .din_valid(validV[0]),
        .din_ready(readyV[0]), .pwm_out(pwmV[0]), .period_start(psV[0]), .underrun(urV[0])
    );

    pwm_dac_ns #(.IN_W(12), .CNT_W(10), .CENTER(1), .NOISE_SHAPE(0)) dutCenter (
        .clk(clk), .rst_n(rstV[1]), .din(dinV[1]), .din_valid(validV[1]),
        .din_ready(readyV[1]), .pwm_out(pwmV[1]), .period_start(psV[1]), .underrun(urV[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushExp(input int idx, input int high, input bit ur);
        expEntry_t e;
        e.high = high;
        e.ur   = ur;
        expQ[idx].push_back(e);
    endtask

    task automatic waitStart(input int idx, output int n);
        n = 0;
        repeat (5000) begin
            @(negedge clk);
            n++;
            if (psV[idx]) return;
        end
        check($sformatf("dut%0d_period_start_timeout", idx), 0, 1);
    endtask

    // Offer a sample right after a period start, then try to overwrite it while full.
    task automatic sendSample(input int idx, input int v, input int high);
        dinV[idx]   = IN_W'(v);
        validV[idx] = 1'b1;
        @(posedge clk);
        #1;
        pushExp(idx, high, 1'b0);
        dinV[idx] = ~dinV[idx];
        @(negedge clk);
        check($sformatf("dut%0d_ready_when_full", idx), int'(readyV[idx]), 0);
        repeat (2) @(negedge clk);
        validV[idx] = 1'b0;
    endtask

    task automatic monitor(input int idx);
        expEntry_t cur;
        bit measuring = 1'b0;
        int highCnt   = 0;
        cur.high = 0;
        cur.ur   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstV[idx]) begin
                measuring = 1'b0;
            end else begin
                if (psV[idx]) begin
                    if (measuring)
                        check($sformatf("dut%0d_high_clks", idx), highCnt, cur.high);
                    if (expQ[idx].size() > 0) begin
                        cur = expQ[idx].pop_front();
                        check($sformatf("dut%0d_underrun_at_start", idx), int'(urV[idx]), int'(cur.ur));
                        measuring = 1'b1;
                        highCnt   = 0;
                    end else begin
                        measuring = 1'b0;
                    end
                end else begin
                    check($sformatf("dut%0d_underrun_stray", idx), int'(urV[idx]), 0);
                end
                if (measuring) highCnt += int'(pwmV[idx]);
            end
        end
    endtask

    // Edge-aligned, noise-shaped: duty values hand-derived with the error carry.
    task automatic driveEdge();
        int n;
        int dinTab  [11] = '{0, 0, -2048, 2047, 2047, 1, 1, 1, 1, 0, -1};
        int dutyTab [11] = '{512, 512, 0, 1023, 1023, 512, 512, 512, 513, 513, 511};
        bit skipTab [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        waitStart(0, n);
        check("dut0_first_start_latency", n, 1);
        for (int i = 0; i < 11; i++) begin
            check("dut0_ready_at_start", int'(readyV[0]), 1);
            if (skipTab[i]) pushExp(0, dutyTab[i], 1'b1);
            else            sendSample(0, dinTab[i], dutyTab[i]);
            waitStart(0, n);
        end
        waitStart(0, n);
    endtask

    // Center-aligned, truncating: high clocks are twice the duty; ends with a mid-period reset.
    task automatic driveCenter();
        int n;
        int dinTab  [5] = '{0, 1, 2047, -2048, 5};
        int dutyTab [5] = '{512, 512, 1023, 0, 513};
        waitStart(1, n);
        check("dut1_first_start_latency", n, 1);
        for (int i = 0; i < 5; i++) begin
            check("dut1_ready_at_start", int'(readyV[1]), 1);
            sendSample(1, dinTab[i], 2 * dutyTab[i]);
            waitStart(1, n);
        end
        repeat (100) @(negedge clk);
        check("dut1_pwm_high_before_reset", int'(pwmV[1]), 1);
        #2 rstV[1] = 1'b0;
        #1;
        check("dut1_pwm_async_reset", int'(pwmV[1]), 0);
        check("dut1_ps_async_reset", int'(psV[1]), 0);
        check("dut1_ready_async_reset", int'(readyV[1]), 1);
        repeat (3) @(negedge clk);
        expQ[1].delete();
        pushExp(1, 1024, 1'b1);
        rstV[1] = 1'b1;
        waitStart(1, n);
        check("dut1_restart_latency", n, 1);
        check("dut1_ready_after_restart", int'(readyV[1]), 1);
        sendSample(1, 0, 1024);
        waitStart(1, n);
        waitStart(1, n);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 2; i++) begin
            rstV[i]   = 1'b0;
            dinV[i]   = '0;
            validV[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d_reset_pwm", i), int'(pwmV[i]), 0);
            check($sformatf("dut%0d_reset_ps", i), int'(psV[i]), 0);
            check($sformatf("dut%0d_reset_underrun", i), int'(urV[i]), 0);
            check($sformatf("dut%0d_reset_ready", i), int'(readyV[i]), 1);
        end
        // Reset duty is mid-scale and the first period always underruns.
        pushExp(0, 512, 1'b1);
        pushExp(1, 1024, 1'b1);
        @(negedge clk);
        rstV[0] = 1'b1;
        rstV[1] = 1'b1;
        fork
            monitor(0);
            monitor(1);
            begin
                #2_000_000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none
        fork
            driveEdge();
            driveCenter();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
